// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, datapath widths and the
// request-arbiter FSM state type.
package alu_pkg;

  localparam int OP_W   = 2;
  localparam int OPND_W = 3;
  localparam int RES_W  = 6;

  localparam logic [OP_W-1:0] OP_XNOR  = 2'b00;
  localparam logic [OP_W-1:0] OP_SHIFT = 2'b01;
  localparam logic [OP_W-1:0] OP_ADD   = 2'b10;
  localparam logic [OP_W-1:0] OP_MULT  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } arb_state_t;

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Two-requester valid/ready bundle with a shared result bus.
// master = operand sources, slave = alu_req_arbiter.
interface alu_req_arbiter_if;
  import alu_pkg::*;

  logic              r0_valid;
  logic              r0_ready;
  logic [OP_W-1:0]   r0_op;
  logic [OPND_W-1:0] r0_a;
  logic [OPND_W-1:0] r0_b;
  logic              r0_rsp_valid;

  logic              r1_valid;
  logic              r1_ready;
  logic [OP_W-1:0]   r1_op;
  logic [OPND_W-1:0] r1_a;
  logic [OPND_W-1:0] r1_b;
  logic              r1_rsp_valid;

  logic [RES_W-1:0]  rsp_data;

  modport master (
    output r0_valid, r0_op, r0_a, r0_b,
    output r1_valid, r1_op, r1_a, r1_b,
    input  r0_ready, r0_rsp_valid,
    input  r1_ready, r1_rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  r0_valid, r0_op, r0_a, r0_b,
    input  r1_valid, r1_op, r1_a, r1_b,
    output r0_ready, r0_rsp_valid,
    output r1_ready, r1_rsp_valid,
    output rsp_data
  );

endinterface

// File: rtl/alu_rr_arbiter.sv
// 2-way grant. ALU_ARB_RR_EN selects round-robin; otherwise
// fixed priority with r0 winning.
module alu_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef ALU_ARB_RR_EN
  // Set when r1 won last; reset value lets r0 win first.
  logic last_r1;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (1'b1)
        (req == 2'b11): gnt = last_r1 ? 2'b01 : 2'b10;
        (req == 2'b01): gnt = 2'b01;
        (req == 2'b10): gnt = 2'b10;
        default:        gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r1 <= 1'b1;
    end else if (gnt[1]) begin
      last_r1 <= 1'b1;
    end else if (gnt[0]) begin
      last_r1 <= 1'b0;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  assign gnt = en ? {req[1] & ~req[0], req[0]} : 2'b00;
`endif

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between two requesters: accept, issue, wait LAT,
// capture, respond. Build with ALU_ARB_RR_EN for round-robin.
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_req_arbiter_if.slave  req,
  output logic              alu_en,
  output logic [OP_W-1:0]   alu_op,
  output logic [OPND_W-1:0] alu_a,
  output logic [OPND_W-1:0] alu_b,
  input  logic [RES_W-1:0]  alu_dout,
  output logic              busy,
  output logic              grant_id
);

  arb_state_t state;
  logic [2:0] cnt;
  logic [1:0] gnt;
  logic       idle;

  assign idle = (state == S_IDLE);

  alu_rr_arbiter u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (idle),
    .req   ({req.r1_valid, req.r0_valid}),
    .gnt   (gnt)
  );

  assign req.r0_ready = gnt[0];
  assign req.r1_ready = gnt[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      cnt              <= '0;
      alu_en           <= 1'b0;
      alu_op           <= '0;
      alu_a            <= '0;
      alu_b            <= '0;
      busy             <= 1'b0;
      grant_id         <= 1'b0;
      req.rsp_data     <= '0;
      req.r0_rsp_valid <= 1'b0;
      req.r1_rsp_valid <= 1'b0;
    end else begin
      alu_en           <= 1'b0;
      req.r0_rsp_valid <= 1'b0;
      req.r1_rsp_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (|gnt) begin
            state    <= S_ISSUE;
            busy     <= 1'b1;
            alu_en   <= 1'b1;
            grant_id <= gnt[1];
            alu_op   <= gnt[1] ? req.r1_op : req.r0_op;
            alu_a    <= gnt[1] ? req.r1_a  : req.r0_a;
            alu_b    <= gnt[1] ? req.r1_b  : req.r0_b;
          end
        end
        S_ISSUE: begin
          cnt   <= 3'(LAT);
          state <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            req.rsp_data     <= alu_dout;
            req.r0_rsp_valid <= ~grant_id;
            req.r1_rsp_valid <= grant_id;
            state            <= S_RESP;
          end
        end
        S_RESP: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: LAT=1 and LAT=4 instances, each
// with a latency-accurate ALU model; directed and random tests.
module tb_alu_req_arbiter;
  import alu_pkg::*;

  localparam int LA = 1;
  localparam int LB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_req_arbiter_if ia ();
  alu_req_arbiter_if ib ();

  logic              en_a, en_b, busy_a, busy_b, gid_a, gid_b;
  logic [OP_W-1:0]   op_a, op_b;
  logic [OPND_W-1:0] xa_a, xb_a, xa_b, xb_b;
  logic [RES_W-1:0]  dout_a, dout_b;
  logic [7:0]        hist_a, hist_b;

  int checks = 0;
  int errors = 0;

  function automatic logic [5:0] alu_f(input logic [1:0] op,
                                       input logic [2:0] a,
                                       input logic [2:0] b);
    logic [5:0] a6;
    a6 = {3'b000, a};
    case (op)
      2'b00:   return {3'b000, ~(a ^ b)};
      2'b01:   return a6 << b;
      2'b10:   return a6 + {3'b000, b};
      default: return a6 * {3'b000, b};
    endcase
  endfunction

  alu_req_arbiter #(.LAT(LA)) u_a (
    .clk(clk), .rst_n(rst_n), .req(ia.slave),
    .alu_en(en_a), .alu_op(op_a), .alu_a(xa_a), .alu_b(xb_a),
    .alu_dout(dout_a), .busy(busy_a), .grant_id(gid_a)
  );

  alu_req_arbiter #(.LAT(LB)) u_b (
    .clk(clk), .rst_n(rst_n), .req(ib.slave),
    .alu_en(en_b), .alu_op(op_b), .alu_a(xa_b), .alu_b(xb_b),
    .alu_dout(dout_b), .busy(busy_b), .grant_id(gid_b)
  );

  // ALU result is only correct exactly LAT cycles after alu_en.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_a <= '0;
      hist_b <= '0;
    end else begin
      hist_a <= {hist_a[6:0], en_a};
      hist_b <= {hist_b[6:0], en_b};
    end
  end

  assign dout_a = hist_a[LA-1] ? alu_f(op_a, xa_a, xb_a)
                               : ~alu_f(op_a, xa_a, xb_a);
  assign dout_b = hist_b[LB-1] ? alu_f(op_b, xa_b, xb_b)
                               : ~alu_f(op_b, xa_b, xb_b);

  function automatic logic [20:0] obs_a();
    return {ia.r0_ready, ia.r1_ready, ia.r0_rsp_valid,
            ia.r1_rsp_valid, ia.rsp_data, en_a, op_a, xa_a,
            xb_a, busy_a, gid_a};
  endfunction

  function automatic logic [20:0] obs_b();
    return {ib.r0_ready, ib.r1_ready, ib.r0_rsp_valid,
            ib.r1_rsp_valid, ib.rsp_data, en_b, op_b, xa_b,
            xb_b, busy_b, gid_b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (obs_a() !== '0) begin
      errors++;
      $display("FAIL reset_a got %h want 0", obs_a());
    end
    checks++;
    if (obs_b() !== '0) begin
      errors++;
      $display("FAIL reset_b got %h want 0", obs_b());
    end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      @(negedge clk);
      checks++;
      if (obs_a() !== '0) begin
        errors++;
        $display("FAIL idle_a c=%0d got %h want 0", c, obs_a());
      end
      checks++;
      if (obs_b() !== '0) begin
        errors++;
        $display("FAIL idle_b c=%0d got %h want 0", c, obs_b());
      end
    end
  endtask

  task automatic test_single_lat1();
    tick();
    ia.r0_valid = 1'b1;
    ia.r0_op = OP_ADD;
    ia.r0_a = 3'd3;
    ia.r0_b = 3'd4;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (ia.r0_ready !== (c == 0)) begin
        errors++;
        $display("FAIL lat1_ready c=%0d got %b want %b",
                 c, ia.r0_ready, c == 0);
      end
      checks++;
      if (en_a !== (c == 1)) begin
        errors++;
        $display("FAIL lat1_alu_en c=%0d got %b want %b",
                 c, en_a, c == 1);
      end
      checks++;
      if (ia.r0_rsp_valid !== (c == 3)) begin
        errors++;
        $display("FAIL lat1_rsp_valid c=%0d got %b want %b",
                 c, ia.r0_rsp_valid, c == 3);
      end
      checks++;
      if (ia.r1_rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL lat1_r1_rsp c=%0d got %b want 0",
                 c, ia.r1_rsp_valid);
      end
      if (c >= 3) begin
        checks++;
        if (ia.rsp_data !== 6'd7) begin
          errors++;
          $display("FAIL lat1_data c=%0d got %0d want 7",
                   c, ia.rsp_data);
        end
      end
      tick();
      ia.r0_valid = 1'b0;
    end
  endtask

  task automatic test_lat4_mult();
    tick();
    ib.r1_valid = 1'b1;
    ib.r1_op = OP_MULT;
    ib.r1_a = 3'd7;
    ib.r1_b = 3'd7;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      checks++;
      if (ib.r1_ready !== (c == 0)) begin
        errors++;
        $display("FAIL lat4_ready c=%0d got %b want %b",
                 c, ib.r1_ready, c == 0);
      end
      checks++;
      if (en_b !== (c == 1)) begin
        errors++;
        $display("FAIL lat4_alu_en c=%0d got %b want %b",
                 c, en_b, c == 1);
      end
      checks++;
      if ({ib.r1_rsp_valid, ib.r0_rsp_valid} !== {c == 6, 1'b0}) begin
        errors++;
        $display("FAIL lat4_rsp c=%0d got %b%b want %b0", c,
                 ib.r1_rsp_valid, ib.r0_rsp_valid, c == 6);
      end
      if (c >= 1) begin
        checks++;
        if ({op_b, xa_b, xb_b} !== {OP_MULT, 3'd7, 3'd7}) begin
          errors++;
          $display("FAIL lat4_hold c=%0d got %b/%0d/%0d want 11/7/7",
                   c, op_b, xa_b, xb_b);
        end
      end
      if (c == 6) begin
        checks++;
        if ({ib.rsp_data, gid_b} !== {6'd49, 1'b1}) begin
          errors++;
          $display("FAIL lat4_data got %0d gid %b want 49 gid 1",
                   ib.rsp_data, gid_b);
        end
      end
      tick();
      ib.r1_valid = 1'b0;
    end
  endtask

  task automatic test_contention();
    logic [5:0] want;
    want = alu_f(OP_XNOR, 3'd5, 3'd1);
    tick();
    ib.r0_valid = 1'b1;
    ib.r0_op = OP_ADD;
    ib.r0_a = 3'd1;
    ib.r0_b = 3'd2;
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      checks++;
      if ({ib.r0_ready, ib.r1_ready} !== {c == 0, c == 7}) begin
        errors++;
        $display("FAIL cont_ready c=%0d got %b%b want %b%b", c,
                 ib.r0_ready, ib.r1_ready, c == 0, c == 7);
      end
      checks++;
      if ({ib.r0_rsp_valid, ib.r1_rsp_valid} !== {c == 6, c == 13}) begin
        errors++;
        $display("FAIL cont_rsp c=%0d got %b%b want %b%b", c,
                 ib.r0_rsp_valid, ib.r1_rsp_valid, c == 6, c == 13);
      end
      if (c == 13) begin
        checks++;
        if (ib.rsp_data !== want) begin
          errors++;
          $display("FAIL cont_data got %0d want %0d",
                   ib.rsp_data, want);
        end
      end
      tick();
      if (c == 0) begin
        ib.r0_valid = 1'b0;
        ib.r1_valid = 1'b1;
        ib.r1_op = OP_XNOR;
        ib.r1_a = 3'd5;
        ib.r1_b = 3'd1;
      end
      if (c == 7) ib.r1_valid = 1'b0;
    end
  endtask

  task automatic test_arbitration();
    int n;
    int want;
    logic r1_seen;
    n = 0;
    r1_seen = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ib.r0_valid = 1'b1;
    ib.r0_op = OP_ADD;
    ib.r0_a = 3'd1;
    ib.r0_b = 3'd1;
    ib.r1_valid = 1'b1;
    ib.r1_op = OP_ADD;
    ib.r1_a = 3'd2;
    ib.r1_b = 3'd2;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (ib.r1_ready) r1_seen = 1'b1;
      if (ib.r0_ready || ib.r1_ready) begin
`ifdef ALU_ARB_RR_EN
        want = n % 2;
`else
        want = 0;
`endif
        checks++;
        if ({ib.r0_ready, ib.r1_ready} !== {want == 0, want == 1}) begin
          errors++;
          $display("FAIL arb_grant n=%0d got %b%b want r%0d", n,
                   ib.r0_ready, ib.r1_ready, want);
        end
        n++;
      end
      tick();
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL arb_timeout got %0d grants want 4", n);
    end
`ifndef ALU_ARB_RR_EN
    checks++;
    if (r1_seen !== 1'b0) begin
      errors++;
      $display("FAIL arb_starve r1_ready seen %b want 0", r1_seen);
    end
`endif
    ib.r0_valid = 1'b0;
    ib.r1_valid = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_reset_mid();
    logic bad;
    bad = 1'b0;
    tick();
    ib.r0_valid = 1'b1;
    ib.r0_op = OP_SHIFT;
    ib.r0_a = 3'd3;
    ib.r0_b = 3'd2;
    tick();
    ib.r0_valid = 1'b0;
    repeat (2) tick();
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_b() !== '0) begin
      errors++;
      $display("FAIL midrst_b got %h want 0", obs_b());
    end
    checks++;
    if (obs_a() !== '0) begin
      errors++;
      $display("FAIL midrst_a got %h want 0", obs_a());
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      @(negedge clk);
      if (ib.r0_rsp_valid || ib.r1_rsp_valid || busy_b) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL midrst_dropped got rsp/busy %b want 0", bad);
    end
    tick();
    ib.r1_valid = 1'b1;
    ib.r1_op = OP_SHIFT;
    ib.r1_a = 3'd3;
    ib.r1_b = 3'd2;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      checks++;
      if (ib.r1_rsp_valid !== (c == 6)) begin
        errors++;
        $display("FAIL midrst_rsp c=%0d got %b want %b",
                 c, ib.r1_rsp_valid, c == 6);
      end
      if (c == 6) begin
        checks++;
        if (ib.rsp_data !== 6'd12) begin
          errors++;
          $display("FAIL midrst_data got %0d want 12", ib.rsp_data);
        end
      end
      tick();
      ib.r1_valid = 1'b0;
    end
  endtask

  task automatic test_random();
    int ph;
    int last_id;
    logic w0, w1, acc0, acc1, m_gid;
    logic [1:0] m_op;
    logic [2:0] m_a, m_b;
    logic [5:0] m_data;
    logic [20:0] want;
    ph = -1;
    last_id = 1;
    acc0 = 1'b0;
    acc1 = 1'b0;
    m_gid = 1'b0;
    m_op = '0;
    m_a = '0;
    m_b = '0;
    m_data = '0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (acc0) ib.r0_valid = 1'b0;
      if (acc1) ib.r1_valid = 1'b0;
      if (!ib.r0_valid && $urandom_range(0, 2) == 0) begin
        ib.r0_valid = 1'b1;
        ib.r0_op = 2'($urandom_range(0, 3));
        ib.r0_a = 3'($urandom_range(0, 7));
        ib.r0_b = 3'($urandom_range(0, 7));
      end
      if (!ib.r1_valid && $urandom_range(0, 2) == 0) begin
        ib.r1_valid = 1'b1;
        ib.r1_op = 2'($urandom_range(0, 3));
        ib.r1_a = 3'($urandom_range(0, 7));
        ib.r1_b = 3'($urandom_range(0, 7));
      end
      @(negedge clk);
      w0 = 1'b0;
      w1 = 1'b0;
      if (ph < 0) begin
        if (ib.r0_valid && ib.r1_valid) begin
`ifdef ALU_ARB_RR_EN
          w0 = (last_id == 1);
          w1 = (last_id == 0);
`else
          w0 = 1'b1;
`endif
        end else begin
          w0 = ib.r0_valid;
          w1 = ib.r1_valid;
        end
      end
      want = {w0, w1, ph == LB + 2 && !m_gid, ph == LB + 2 && m_gid,
              m_data, ph == 1, m_op, m_a, m_b, ph >= 1, m_gid};
      checks++;
      if (obs_b() !== want) begin
        errors++;
        $display("FAIL random i=%0d got %h want %h", i, obs_b(), want);
      end
      acc0 = w0;
      acc1 = w1;
      if (w0 || w1) begin
        m_gid = w1;
        last_id = w1 ? 1 : 0;
        m_op = w1 ? ib.r1_op : ib.r0_op;
        m_a = w1 ? ib.r1_a : ib.r0_a;
        m_b = w1 ? ib.r1_b : ib.r0_b;
        ph = 1;
      end else if (ph >= 1) begin
        if (ph == LB + 1) m_data = alu_f(m_op, m_a, m_b);
        ph = (ph == LB + 2) ? -1 : ph + 1;
      end
    end
    tick();
    ib.r0_valid = 1'b0;
    ib.r1_valid = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    ia.r0_valid = 1'b0; ia.r0_op = '0; ia.r0_a = '0; ia.r0_b = '0;
    ia.r1_valid = 1'b0; ia.r1_op = '0; ia.r1_a = '0; ia.r1_b = '0;
    ib.r0_valid = 1'b0; ib.r0_op = '0; ib.r0_a = '0; ib.r0_b = '0;
    ib.r1_valid = 1'b0; ib.r1_op = '0; ib.r1_a = '0; ib.r1_b = '0;
    test_reset();
    test_single_lat1();
    test_lat4_mult();
    test_contention();
    test_arbitration();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
